// File: rtl/triangular_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | triangular_counter_if : output bundle of the triangular counter      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface triangular_counter_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] value;
   logic             dir;
   logic             at_max;
   logic             at_min;

   modport master (output value, dir, at_max, at_min);
   modport slave  (input  value, dir, at_max, at_min);
endinterface
`default_nettype wire

// File: rtl/triangular_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | triangular_counter : free-running 0..MAX..0 up/down ramp generator   |
// | Option macro TRI_COUNTER_DWELL_EN : hold each endpoint two cycles    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module triangular_counter #(
   parameter int WIDTH = 8
) (
   input  wire logic            clk,
   input  wire logic            rst,
   triangular_counter_if.master cnt_if
);
   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] value_q, value_d;
   logic             dir_q, dir_d;
   logic             endpoint;
   logic             turn;
   logic             hold;

`ifdef TRI_COUNTER_DWELL_EN
   logic dwell_q, dwell_d;
`endif

   assign endpoint = dir_q ? (value_q == MAX) : (value_q == '0);

`ifdef TRI_COUNTER_DWELL_EN
   // First endpoint cycle only arms the dwell flag; the turn happens on the second.
   assign hold = endpoint && !dwell_q;
   assign turn = endpoint &&  dwell_q;
`else
   assign hold = 1'b0;
   assign turn = endpoint;
`endif

   always_comb begin
      value_d = value_q;
      dir_d   = dir_q;
`ifdef TRI_COUNTER_DWELL_EN
      dwell_d = hold;
`endif
      if (turn) begin
         dir_d   = !dir_q;
         value_d = dir_q ? (MAX - ONE) : ONE;
      end else if (!hold) begin
         value_d = dir_q ? (value_q + ONE) : (value_q - ONE);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         value_q <= '0;
         dir_q   <= 1'b1;
`ifdef TRI_COUNTER_DWELL_EN
         dwell_q <= 1'b0;
`endif
      end else begin
         value_q <= value_d;
         dir_q   <= dir_d;
`ifdef TRI_COUNTER_DWELL_EN
         dwell_q <= dwell_d;
`endif
      end
   end

   assign cnt_if.value  = value_q;
   assign cnt_if.dir    = dir_q;
   assign cnt_if.at_max = (value_q == MAX);
   assign cnt_if.at_min = (value_q == '0);
endmodule
`default_nettype wire

// File: tb/tb_triangular_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_triangular_counter : scoreboard + table bench, WIDTH 8 and 2 DUTs  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_triangular_counter;
`ifdef TRI_COUNTER_DWELL_EN
   localparam bit DWELL = 1'b1;
`else
   localparam bit DWELL = 1'b0;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   n_edges;

   triangular_counter_if #(.WIDTH(8)) if8();
   triangular_counter_if #(.WIDTH(2)) if2();

   triangular_counter #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .cnt_if(if8));
   triangular_counter #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .cnt_if(if2));

   typedef struct {
      int v8;
      bit d8;
      int v2;
      bit d2;
   } exp_t;

   typedef struct {
      bit   rst_val;
      int   cycles;
      int   exp_value;
      bit   exp_dir;
      bit   exp_max;
      bit   exp_min;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[15];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Closed-form expectation from the number of counting edges since reset release.
   function automatic void model(input int n, input int maxv, output int v, output bit d);
      int period;
      int p;
      period = DWELL ? 2 * maxv + 2 : 2 * maxv;
      p      = n % period;
      if (p <= maxv)                 v = p;
      else if (DWELL && p == maxv+1) v = maxv;
      else                           v = DWELL ? (2 * maxv + 1 - p) : (2 * maxv - p);
      d = (n == 0) || (p >= 1 && p <= (DWELL ? maxv + 1 : maxv));
   endfunction

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("value8",  int'(if8.value),  e.v8);
         check("dir8",    int'(if8.dir),    int'(e.d8));
         check("at_max8", int'(if8.at_max), int'(e.v8 == 255));
         check("at_min8", int'(if8.at_min), int'(e.v8 == 0));
         check("value2",  int'(if2.value),  e.v2);
         check("dir2",    int'(if2.dir),    int'(e.d2));
         check("at_max2", int'(if2.at_max), int'(e.v2 == 3));
         check("at_min2", int'(if2.at_min), int'(e.v2 == 0));
      end
   end

   task automatic drive(input bit r);
      exp_t e;
      @(negedge clk);
      rst = r;
      n_edges = r ? n_edges + 1 : 0;
      model(n_edges, 255, e.v8, e.d8);
      model(n_edges, 3,   e.v2, e.d2);
      sb_q.push_back(e);
   endtask

   initial begin
      int wait_cycles;
      total   = 0;
      bad     = 0;
      n_edges = 0;
      rst     = 1'b0;

      vecs[0]  = '{1'b0,   5, 0,                   1'b1,  1'b0, 1'b1};
      vecs[1]  = '{1'b1,   1, 1,                   1'b1,  1'b0, 1'b0};
      vecs[2]  = '{1'b1,   9, 10,                  1'b1,  1'b0, 1'b0};
      vecs[3]  = '{1'b1, 245, 255,                 1'b1,  1'b1, 1'b0};
      vecs[4]  = '{1'b1,   1, DWELL ? 255 : 254,   DWELL, DWELL, 1'b0};
      vecs[5]  = '{1'b1, 254, DWELL ? 1 : 0,       1'b0,  1'b0, !DWELL};
      vecs[6]  = '{1'b1,   1, DWELL ? 0 : 1,       !DWELL, 1'b0, DWELL};
      vecs[7]  = '{1'b1,  89, DWELL ? 88 : 90,     1'b1,  1'b0, 1'b0};
      vecs[8]  = '{1'b0,   1, 0,                   1'b1,  1'b0, 1'b1};
      vecs[9]  = '{1'b1, DWELL ? 374 : 373, 137,   1'b0,  1'b0, 1'b0};
      vecs[10] = '{1'b0,   1, 0,                   1'b1,  1'b0, 1'b1};
      vecs[11] = '{1'b1,   1, 1,                   1'b1,  1'b0, 1'b0};
      vecs[12] = '{1'b1,   1, 2,                   1'b1,  1'b0, 1'b0};
      vecs[13] = '{1'b0, 100, 0,                   1'b1,  1'b0, 1'b1};
      vecs[14] = '{1'b1,   1, 1,                   1'b1,  1'b0, 1'b0};

      for (int i = 0; i < 15; i++) begin
         for (int c = 0; c < vecs[i].cycles; c++) drive(vecs[i].rst_val);
         @(posedge clk);
         #2;
         check($sformatf("vec%0d_value", i),  int'(if8.value),  vecs[i].exp_value);
         check($sformatf("vec%0d_dir", i),    int'(if8.dir),    int'(vecs[i].exp_dir));
         check($sformatf("vec%0d_at_max", i), int'(if8.at_max), int'(vecs[i].exp_max));
         check($sformatf("vec%0d_at_min", i), int'(if8.at_min), int'(vecs[i].exp_min));
      end

      // Small-width run covering several full periods, including both endpoints.
      drive(1'b0);
      for (int c = 0; c < 20; c++) drive(1'b1);

      wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      check("scoreboard_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/triangular_counter.md
# triangular_counter

Free-running up/down counter producing a triangular waveform on a WIDTH-bit output. It counts from 0 to its maximum, back down to 0, and repeats indefinitely with no input other than clock and reset. It serves as a self-contained pattern/stimulus source, for example as a PWM reference ramp, a DAC test pattern or a debug waveform.

## Interface
- WIDTH, default 8: bit width of `value`; legal range 2..32; MAX = 2^WIDTH − 1.
- clk  input  1  single clock domain; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0), sampled on the rising edge of clk.
- value  output  WIDTH  current count; registered, no combinational path from any input.
- dir  output  1  current direction register: 1 = counting up, 0 = counting down.
- at_max  output  1  high while value == MAX.
- at_min  output  1  high while value == 0.

## Operation
- State: `value` register (WIDTH bits), `dir` register, plus a dwell flag when DWELL is compiled in.
- Reset (rst == 0 at a rising edge): value ← 0, dir ← 1 (up), dwell flag ← 0. Reset has priority over counting at any point, including at the endpoints and in the middle of a ramp.
- Up phase (dir == 1):
  - value < MAX: value ← value + 1.
  - value == MAX: dir ← 0 and value ← MAX − 1. The peak is not repeated.
- Down phase (dir == 0):
  - value > 0: value ← value − 1.
  - value == 0: dir ← 1 and value ← 1. The trough is not repeated.
- Resulting sequence after reset: 0,1,…,MAX,MAX−1,…,1,0,1,… with a period of 2·MAX cycles (510 for WIDTH = 8).
- Arithmetic:
  - Unsigned, WIDTH bits.
  - Value never wraps: it never goes from MAX to 0 or from 0 to MAX.
  - No overflow or underflow is reachable.
- at_max and at_min are decoded directly from the `value` register. They are never high simultaneously for WIDTH ≥ 2.
- `dir` reflects the direction of the next step, except on the endpoint cycle itself, where it still holds the old direction and flips on the following edge.

## Timing
- All outputs are updated on the rising edge of clk only.
- Reset: value = 0, dir = 1, at_min = 1 and at_max = 0 on the first edge with rst == 0, held for as long as reset stays low.
- The first edge with rst == 1 moves value from 0 to 1. Latency from reset release to the first count is one cycle.
- Peak: value == MAX for exactly one cycle, and dir reads 0 from the following cycle.
- Trough: value == 0 for exactly one cycle after the first cycle of counting, and dir reads 1 from the following cycle.
- Reset asserted mid-ramp: the next edge forces value to 0 and dir to 1 regardless of the current state.

## Configuration
- Macro: TRI_COUNTER_DWELL_EN.
- Defined:
  - The counter holds each endpoint for two consecutive cycles.
  - Sequence: 0,1,…,MAX,MAX,MAX−1,…,1,0,0,1,…
  - Period: 2·MAX + 2 cycles (512 for WIDTH = 8).
  - Implemented with a dwell flag that is set on the first endpoint cycle and cleared on the second, when dir flips.
  - The post-reset value of 0 counts as the first trough cycle, so the first edge after release still gives 1.
- Not defined: behaviour is exactly as in Operation, the dwell flag is absent, and the period is 2·MAX.

## Test plan
All scenarios use WIDTH = 8 unless stated otherwise.
- Reset for 5 cycles, then release: value == 0 and at_min == 1 during reset; value == 1 on the first edge after release; value == 10 after 10 edges.
- Run from reset release to the peak: value == 255 with at_max == 1 after 255 edges; 254 after 256 edges; dir == 0 from edge 256.
- Run for 600 cycles: value == 0 at edge 510, value == 1 at edge 511, and value == 90 at edge 600. Every adjacent pair of samples differs by exactly 1.
- Assert rst for 1 cycle when value == 137 and counting down: the next value is 0 with dir == 1, followed by 1, 2, … after release.
- WIDTH = 2 with TRI_COUNTER_DWELL_EN defined: after release, the sequence is 1,2,3,3,2,1,0,0,1 with a period of 8.
- Hold rst low continuously for 100 cycles: value stays 0 and dir stays 1 throughout.
